// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic controller time-parameter reprogram path.
package traffic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StGap,
    StDone
  } prog_state_e;

  localparam logic [1:0] SEL_BASE = 2'd0;
  localparam logic [1:0] SEL_EXT  = 2'd1;
  localparam logic [1:0] SEL_YEL  = 2'd2;
  localparam logic [1:0] SEL_WALK = 2'd3;

  localparam int unsigned DEF_SETUP_CYC = 2;
  localparam int unsigned DEF_PULSE_CYC = 4;
  localparam int unsigned DEF_GAP_CYC   = 4;

  function automatic logic [3:0] get_nibble(input logic [15:0] tbl, input logic [1:0] idx);
    return tbl[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/param_programmer_if.sv
// Load request and reprogram-bus signals between test logic and param_programmer.
interface param_programmer_if;

    logic        Load;
    logic [15:0] Prog_Table;
    logic [3:0]  Write_Mask;
    logic        Reprogram;
    logic [1:0]  Time_Parameter_Selector;
    logic [3:0]  Time_Value;
    logic        Busy;
    logic        Done;
    logic [2:0]  Written;

    modport master (
        output Load, Prog_Table, Write_Mask,
        input  Reprogram, Time_Parameter_Selector, Time_Value, Busy, Done, Written
    );

    modport slave (
        input  Load, Prog_Table, Write_Mask,
        output Reprogram, Time_Parameter_Selector, Time_Value, Busy, Done, Written
    );

endinterface

// File: rtl/mask_next_index.sv
// Priority search: lowest set mask bit at or above start, with a found flag.
module mask_next_index (
    input  logic [3:0] mask,
    input  logic [2:0] start,
    output logic [1:0] idx,
    output logic       found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        // Scan downward so the lowest qualifying bit is the last one assigned.
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) begin
                idx   = 2'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/param_programmer.sv
// Writes up to four 4-bit time parameters into the traffic controller as timed
// Reprogram transactions (setup, strobe, hold gap) per set Write_Mask bit.
module param_programmer
    import traffic_pkg::*;
#(
    parameter int unsigned SETUP_CYC = DEF_SETUP_CYC,
    parameter int unsigned PULSE_CYC = DEF_PULSE_CYC,
    parameter int unsigned GAP_CYC   = DEF_GAP_CYC
) (
    input logic              clk,
    input logic              Reset_n,
    param_programmer_if.slave bus
);

    localparam int unsigned MaxSp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int unsigned MaxCyc = (MaxSp > GAP_CYC) ? MaxSp : GAP_CYC;
    localparam int unsigned CntW   = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    prog_state_e      state_q;
    logic [CntW-1:0]  cnt_q;
    logic [15:0]      table_q;
    logic [3:0]       mask_q;
    logic [1:0]       sel_q;
    logic [3:0]       val_q;
    logic             reprogram_q;
    logic             busy_q;
    logic             done_q;
    logic [2:0]       written_q;

    logic [3:0]       srch_mask;
    logic [2:0]       srch_start;
    logic [1:0]       srch_idx;
    logic             srch_found;

    // In IDLE search the live inputs; otherwise continue above the index just written.
    always_comb begin
        srch_mask  = mask_q;
        srch_start = {1'b0, sel_q} + 3'd1;
        if (state_q == StIdle) begin
            srch_mask  = bus.Write_Mask;
            srch_start = 3'd0;
        end
    end

    mask_next_index u_mask_next_index (
        .mask  (srch_mask),
        .start (srch_start),
        .idx   (srch_idx),
        .found (srch_found)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            table_q     <= '0;
            mask_q      <= '0;
            sel_q       <= SEL_BASE;
            val_q       <= '0;
            reprogram_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            written_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.Load) begin
                        table_q   <= bus.Prog_Table;
                        mask_q    <= bus.Write_Mask;
                        written_q <= '0;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        if (srch_found) begin
                            state_q <= StSetup;
                            sel_q   <= srch_idx;
                            val_q   <= get_nibble(bus.Prog_Table, srch_idx);
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    if (cnt_q == CntW'(SETUP_CYC - 1)) begin
                        cnt_q       <= '0;
                        reprogram_q <= 1'b1;
                        state_q     <= StPulse;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StPulse: begin
                    if (cnt_q == CntW'(PULSE_CYC - 1)) begin
                        cnt_q       <= '0;
                        reprogram_q <= 1'b0;
                        state_q     <= StGap;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StGap: begin
                    if (cnt_q == CntW'(GAP_CYC - 1)) begin
                        cnt_q <= '0;
                        if (written_q != 3'd4) begin
                            written_q <= written_q + 3'd1;
                        end
                        if (srch_found) begin
                            state_q <= StSetup;
                            sel_q   <= srch_idx;
                            val_q   <= get_nibble(table_q, srch_idx);
                        end else begin
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.Reprogram               = reprogram_q;
    assign bus.Time_Parameter_Selector = sel_q;
    assign bus.Time_Value              = val_q;
    assign bus.Busy                    = busy_q;
    assign bus.Done                    = done_q;
    assign bus.Written                 = written_q;

endmodule

// File: doc/param_programmer.md
Name: param_programmer

Overview:
- Writer side of the controller's time-parameter reprogram interface.
- Drives Reprogram, Time_Parameter_Selector and Time_Value into the traffic controller top level.
- On a Load pulse it writes up to four 4-bit interval values (selectors 0..3) as a sequence of timed reprogram transactions.
- Timing is sized so the controller's input synchronizer and parameter store capture each write reliably. Used by board-level test logic and the bring-up harness.

Parameters:
- SETUP_CYC, 2, cycles Selector/Value are stable before Reprogram rises (≥1).
- PULSE_CYC, 4, cycles Reprogram is held high (≥3, covers the 2-flop synchronizer plus the capture edge).
- GAP_CYC, 4, cycles Reprogram is low after the pulse while Selector/Value stay stable (≥1).

Ports:
- clk  input  1  system clock; all logic rising-edge.
- Reset_n  input  1  asynchronous active-low reset.
- Load  input  1  start request, sampled each clk; honoured only in IDLE.
- Prog_Table  input  16  four values: [3:0]=sel0, [7:4]=sel1, [11:8]=sel2, [15:12]=sel3. Captured on the accepted Load.
- Write_Mask  input  4  bit i=1 means write selector i. Captured on the accepted Load.
- Reprogram  output  1  reprogram strobe to the controller.
- Time_Parameter_Selector  output  2  selector being written.
- Time_Value  output  4  value being written.
- Busy  output  1  high from the accepted Load until Done.
- Done  output  1  one-cycle pulse when the sequence completes.
- Written  output  3  count of writes completed in the current/last sequence (0..4).

Behaviour:
- Reset (Reset_n low, asynchronous):
  - state IDLE; all outputs 0; latched table, latched mask and counters 0.
  - Reset mid-transaction drops Reprogram immediately; no partial pulse resumes after release.
- States: IDLE, SETUP, PULSE, GAP, DONE. A single phase counter is reused per state. Its width is clog2 of the maximum of the three parameters.
- IDLE:
  - Busy=0, Reprogram=0. Selector/Value hold their last driven values (0 after reset).
  - Load=1 at an edge latches Prog_Table and Write_Mask, clears Written and sets Busy=1.
  - If the latched mask has any bit set: go to SETUP at the lowest set index, driving Selector=index and Value=table nibble from that edge.
  - If the mask is 0: go to DONE.
- SETUP: hold for SETUP_CYC cycles, then go to PULSE.
- PULSE: Reprogram=1 for exactly PULSE_CYC cycles, then go to GAP.
- GAP:
  - Reprogram=0 for GAP_CYC cycles; Selector/Value unchanged.
  - On exit Written increments.
  - Go to SETUP for the next higher set mask index (skipping clear bits), else go to DONE.
- DONE:
  - Done=1 for one cycle; Busy stays 1 during that cycle.
  - Next edge goes to IDLE with Busy=0.
- Load while Busy=1 (including DONE) is ignored, with no queuing. Prog_Table and Write_Mask changes while Busy=1 have no effect.
- Timing for the first written index, with the Load edge counted as edge 0:
  - Reprogram rises at edge SETUP_CYC and falls at edge SETUP_CYC+PULSE_CYC.
  - One write occupies S=SETUP_CYC+PULSE_CYC+GAP_CYC cycles.
  - For N set mask bits, Done is high in the cycle after edge N·S.
- Selector/Value never change while Reprogram=1, nor within GAP_CYC cycles after it falls.
- Value 0 is written as-is; no range checking is done.
- Written saturates at 4 and holds its value through IDLE until the next accepted Load.

Decomposition:
- Shared package traffic_pkg holds:
  - state enum for this block;
  - selector constants SEL_BASE=0, SEL_EXT=1, SEL_YEL=2, SEL_WALK=3;
  - default PULSE/SETUP/GAP constants.
- One natural sub-module, mask_next_index: combinational priority search giving the lowest set mask bit above a given index, plus a found flag. Everything else stays in param_programmer.

Test Plan:
- Reset release, then Load with Prog_Table=16'h4A36, Write_Mask=4'b1111 (defaults) -> four Reprogram pulses, each 4 cycles high.
  - Selector/Value sequence: (0,6), (1,3), (2,A), (3,4).
  - First pulse over edges 2–6; Done in the cycle after edge 40; Written=4.
- Write_Mask=4'b1010, Prog_Table=16'h9000 -> exactly two pulses, (1,0) then (3,9).
  - Done in the cycle after edge 20; Written=2.
- Write_Mask=0 -> no Reprogram pulse, Done in the cycle after edge 0, Written=0.
- Load re-pulsed at edge 5 with a changed table -> ignored; output sequence is identical to the first scenario.
- Reset_n low at edge 4 (mid-PULSE) -> Reprogram, Busy and Done are 0 immediately, asynchronously.
  - After release, a new Load runs a full clean sequence.
- Stability checker over all scenarios -> Selector/Value constant from SETUP start through GAP end for every write; Reprogram high run length always PULSE_CYC.
